// File: rtl/alarma_parpadeo_param.sv
// Alarm blinker driven by a timer-expired request. It blinks salida for
// NUM_FASES phases of DIV cycles each, or until ack in continuous mode.
// Ports:
//   clk      system clock, all state changes on the rising edge
//   reset    synchronous, active-high reset
//   irq      alarm request level; only its rising edge starts a sequence
//   ack      user acknowledge, stops blinking at once
//   continuo mode select sampled in ARMA (1 = until ack, 0 = counted)
//   salida   registered blink output
//   activa   registered, high while in ARMA or BLINK
//   fin      registered one-cycle pulse when a counted sequence completes
module alarma_parpadeo_param #(
   parameter int DIV       = 25000000,
   parameter int DIV_W     = 25,
   parameter int NUM_FASES = 10,
   parameter int FASE_W    = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic irq,
   input  logic ack,
   input  logic continuo,
   output logic salida,
   output logic activa,
   output logic fin
);

   typedef enum logic [1:0] {
      IDLE,
      ARMA,
      BLINK,
      DONE
   } state_t;

   localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(DIV - 1);
   localparam logic [FASE_W-1:0] FASE_ULT = FASE_W'(NUM_FASES - 1);

   state_t            state, state_nx;
   logic [DIV_W-1:0]  cnt, cnt_nx;
   logic [FASE_W-1:0] fase, fase_nx;
   logic              modo, modo_nx;
   logic              irq_d;
   logic              salida_nx, activa_nx, fin_nx;
   logic              rise;
   logic              tick;

   assign rise = irq & ~irq_d;
   assign tick = (cnt == DIV_MAX);

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      fase_nx   = fase;
      modo_nx   = modo;
      salida_nx = salida;
      activa_nx = activa;
      fin_nx    = 1'b0;
      unique case (state)
         IDLE: begin
            if (rise) begin
               state_nx  = ARMA;
               salida_nx = 1'b0;
               activa_nx = 1'b1;
            end
         end
         ARMA: begin
            if (ack) begin
               state_nx  = IDLE;
               salida_nx = 1'b0;
               activa_nx = 1'b0;
            end else if (rise) begin
               state_nx  = ARMA;
               salida_nx = 1'b0;
               activa_nx = 1'b1;
            end else begin
               state_nx  = BLINK;
               cnt_nx    = '0;
               fase_nx   = '0;
               modo_nx   = continuo;
               salida_nx = 1'b1;
               activa_nx = 1'b1;
            end
         end
         BLINK: begin
            if (ack) begin
               state_nx  = IDLE;
               salida_nx = 1'b0;
               activa_nx = 1'b0;
            end else if (rise) begin
               state_nx  = ARMA;
               salida_nx = 1'b0;
               activa_nx = 1'b1;
            end else if (tick) begin
               cnt_nx = '0;
               // Last counted phase ends the sequence instead of toggling
               if (!modo && fase == FASE_ULT) begin
                  state_nx  = DONE;
                  salida_nx = 1'b0;
                  activa_nx = 1'b0;
                  fin_nx    = 1'b1;
               end else begin
                  salida_nx = ~salida;
                  if (!modo) begin
                     fase_nx = fase + 1'b1;
                  end
               end
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         DONE: begin
            salida_nx = 1'b0;
            if (rise) begin
               state_nx  = ARMA;
               activa_nx = 1'b1;
            end else begin
               state_nx  = IDLE;
               activa_nx = 1'b0;
            end
         end
         default: begin
            state_nx  = IDLE;
            salida_nx = 1'b0;
            activa_nx = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         fase   <= '0;
         modo   <= 1'b0;
         // Set high so an irq already high at reset release is not an edge
         irq_d  <= 1'b1;
         salida <= 1'b0;
         activa <= 1'b0;
         fin    <= 1'b0;
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         fase   <= fase_nx;
         modo   <= modo_nx;
         irq_d  <= irq;
         salida <= salida_nx;
         activa <= activa_nx;
         fin    <= fin_nx;
      end
   end

endmodule
